// File: rtl/alu_op_driver.sv
// Request/response driver for the 32-bit ALU: issues operands, waits out the ALU latency, returns result.
// Optional result self-check on logic ops enabled by defining ALU_DRV_CHECK_EN.
module alu_op_driver #(
  parameter int unsigned ALU_LATENCY = 3,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             chk_mismatch
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);
  localparam logic [3:0] OP_AND = 4'b0100;

  state_e state_q, state_d;

  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [31:0]      res_q, res_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic             capture;

  assign capture = (state_q == S_WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    zero_d   = zero_q;
    err_d    = err_q;
    rtag_d   = rtag_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          tag_d = req_tag;
          if (req_op[3]) begin
            // Reserved opcode: answer directly, never touch the ALU.
            res_d   = 32'd0;
            zero_d  = 1'b1;
            err_d   = 1'b1;
            rtag_d  = req_tag;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        alu_a_d  = a_q;
        alu_b_d  = b_q;
        alu_op_d = op_q;
        cnt_d    = LAT_M1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (capture) begin
          res_d   = alu_result;
          zero_d  = (alu_result == 32'd0);
          err_d   = 1'b0;
          rtag_d  = tag_q;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 4'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      tag_q    <= '0;
      cnt_q    <= 4'd0;
      alu_a_q  <= 32'd0;
      alu_b_q  <= 32'd0;
      alu_op_q <= OP_AND;
      res_q    <= 32'd0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      rtag_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      rtag_q   <= rtag_d;
    end
  end

`ifdef ALU_DRV_CHECK_EN
  logic [31:0] exp_w;
  logic        chk_q, chk_d;

  always_comb begin
    exp_w = 32'd0;
    unique case (op_q[1:0])
      2'b00: exp_w = a_q & b_q;
      2'b01: exp_w = a_q | b_q;
      2'b10: exp_w = a_q ^ b_q;
      2'b11: exp_w = ~(a_q | b_q);
      default: exp_w = 32'd0;
    endcase
    chk_d = chk_q | (capture && op_q[2] && (alu_result != exp_w));
  end

  always_ff @(posedge clk) begin
    if (reset) chk_q <= 1'b0;
    else       chk_q <= chk_d;
  end

  assign chk_mismatch = chk_q;
`else
  assign chk_mismatch = 1'b0;
`endif

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign rsp_tag    = rtag_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: pipelined ALU stub plus an operation-level reference model.
// Covers directed test-plan cases, response back-pressure, reset mid-op and random ops.
module tb_alu_op_driver;

  localparam int LAT = 3;
  localparam int TW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = 4'd0;
  logic [31:0]   req_a = 32'd0;
  logic [31:0]   req_b = 32'd0;
  logic [TW-1:0] req_tag = '0;
  logic [31:0]   alu_a, alu_b, alu_result;
  logic [3:0]    alu_op;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_result;
  logic          rsp_zero, rsp_err;
  logic [TW-1:0] rsp_tag;
  logic          busy, chk_mismatch;

  alu_op_driver #(.ALU_LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .rsp_tag(rsp_tag), .busy(busy), .chk_mismatch(chk_mismatch)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    if (op[2]) begin
      case (op[1:0])
        2'b00:   return a & b;
        2'b01:   return a | b;
        2'b10:   return a ^ b;
        default: return ~(a | b);
      endcase
    end
    case (op[1:0])
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // ALU stub: result appears LAT-1 clocks after its inputs settle.
  logic [31:0] pipe [0:LAT-2];
  logic        corrupt = 1'b0;
  always_ff @(posedge clk) begin
    pipe[0] <= alu_fn(alu_op, alu_a, alu_b);
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_result = corrupt ? 32'hDEAD_BEEF : pipe[LAT-2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [3:0]  m_op = 4'b0100;
  logic [31:0] m_a  = 32'd0;
  logic [31:0] m_b  = 32'd0;
  logic        m_chk = 1'b0;

  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TW-1:0] tag,
                        input int stall);
    logic [31:0] exp_r;
    int w;
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    rsp_ready = (stall == 0);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("accept_timeout", 64'd1, 64'd0);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), op[3] ? 64'd1 : 64'(LAT + 2));
    if (op[3]) begin
      exp_r = 32'd0;
    end else begin
      exp_r = corrupt ? 32'hDEAD_BEEF : alu_fn(op, a, b);
      m_op = op;
      m_a  = a;
      m_b  = b;
`ifdef ALU_DRV_CHECK_EN
      if (corrupt && op[2] && exp_r != alu_fn(op, a, b)) m_chk = 1'b1;
`endif
    end
    check("rsp_result", 64'(rsp_result), 64'(exp_r));
    check("rsp_zero", 64'(rsp_zero), 64'(exp_r == 32'd0));
    check("rsp_err", 64'(rsp_err), 64'(op[3]));
    check("rsp_tag", 64'(rsp_tag), 64'(tag));
    check("alu_op", 64'(alu_op), 64'(m_op));
    check("alu_a", 64'(alu_a), 64'(m_a));
    check("alu_b", 64'(alu_b), 64'(m_b));
    check("chk_mismatch", 64'(chk_mismatch), 64'(m_chk));
    check("ready_in_resp", 64'(req_ready), 64'd0);
    if (stall > 0) begin
      req_valid = 1'b1;
      req_op    = 4'b0101;
      repeat (stall) begin
        @(negedge clk);
        check("hold_valid", 64'(rsp_valid), 64'd1);
        check("hold_result", 64'(rsp_result), 64'(exp_r));
        check("hold_tag", 64'(rsp_tag), 64'(tag));
        check("hold_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("post_valid", 64'(rsp_valid), 64'd0);
    check("post_ready", 64'(req_ready), 64'd1);
    check("post_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd4);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_result", 64'(rsp_result), 64'd0);
    check("rst_zero", 64'(rsp_zero), 64'd0);
    check("rst_tag", 64'(rsp_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_chk", 64'(chk_mismatch), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(req_ready), 64'd1);

    run_op(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3, 0);
    run_op(4'b0110, 32'h1234_5678, 32'h1234_5678, 4'd5, 0);
    run_op(4'b1010, 32'hAAAA_5555, 32'h0000_FFFF, 4'd9, 0);
    run_op(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 4'd1, 10);
    run_op(4'b0111, 32'h0F0F_0000, 32'h00F0_0000, 4'd12, 2);

    corrupt = 1'b1;
    run_op(4'b0101, 32'h0000_00FF, 32'h0000_FF00, 4'd7, 0);
    corrupt = 1'b0;
    run_op(4'b0101, 32'h1111_0000, 32'h0000_2222, 4'd8, 0);

    for (int k = 0; k < 25; k++)
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom,
             TW'($urandom), int'($urandom_range(0, 3)));

    // Reset while the ALU wait is in progress.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'b0101;
    req_a     = 32'h0000_1234;
    req_b     = 32'h0055_0000;
    req_tag   = 4'd6;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("wait_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_alu_op", 64'(alu_op), 64'd4);
    check("mid_rst_alu_b", 64'(alu_b), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_chk", 64'(chk_mismatch), 64'd0);
    reset = 1'b0;
    m_op  = 4'b0100;
    m_a   = 32'd0;
    m_b   = 32'd0;
    m_chk = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      check("no_rsp_after_rst", 64'(seen), 64'd0);
    end
    check("ready_idle", 64'(req_ready), 64'd1);

    run_op(4'b0001, 32'd100, 32'd58, 4'd2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_chk);
    $fatal(1);
  end

endmodule

// File: doc/alu_op_driver.md
# alu_op_driver

Initiator-side driver for the 32-bit ALU datapath: accepts one operation request at a time over a valid/ready channel, drives the ALU operand and opcode inputs, holds them stable for the ALU's clocked mux latency, then captures the result and returns it with a locally computed zero flag over a valid/ready response channel. It sits between the instruction/control logic and the ALU, and is the only block that drives the ALU's A, B and AluOpCode inputs.

## Interface

Parameters:
- ALU_LATENCY, 3, cycles from stable ALU inputs to a valid ALU result; legal range 1..15.
- TAG_W, 4, width of the request tag returned with the response.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request.
- req_op  in  4  opcode.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_tag  in  TAG_W  caller tag.
- alu_a  out  32  to ALU A.
- alu_b  out  32  to ALU B.
- alu_op  out  4  to ALU AluOpCode.
- alu_result  in  32  from ALU Result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  32  captured result.
- rsp_zero  out  1  1 when rsp_result == 0.
- rsp_err  out  1  1 for a rejected opcode.
- rsp_tag  out  TAG_W  tag of the request.
- busy  out  1  state != IDLE.
- chk_mismatch  out  1  sticky self-check failure (see Configuration).

## Operation

- Opcode map: op[3]=1 reserved/illegal; op[2]=0 arithmetic; op[2]=1 logic with op[1:0] = 00 AND, 01 OR, 10 XOR, 11 NOR.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register op/a/b/tag. Legal op -> ISSUE; illegal op -> RESP with rsp_result=0, rsp_zero=1, rsp_err=1, ALU outputs unchanged.
- ISSUE: alu_a/alu_b/alu_op driven from registers; latency counter loaded with ALU_LATENCY-1; -> WAIT.
- WAIT: counter decrements each cycle; ALU outputs held constant. When counter==0, capture alu_result into rsp_result, rsp_zero = (alu_result==0), rsp_err=0 -> RESP.
- RESP: rsp_valid=1; rsp_* held stable until rsp_valid&&rsp_ready, then -> IDLE. rsp_valid is never withdrawn without a handshake (except reset).
- alu_a/alu_b/alu_op change only on the ISSUE transition; they hold the last issued values otherwise.
- Zero is computed by this block; the ALU provides no zero output.

## Timing

- Reset values: req_ready=0 in the reset cycle, 1 from the first cycle after reset deasserts; rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, rsp_tag=0, alu_a=0, alu_b=0, alu_op=4'b0100 (AND), busy=0, chk_mismatch=0; state IDLE.
- Accept at edge T -> ISSUE in T+1 -> WAIT T+2..T+1+ALU_LATENCY -> rsp_valid high from T+2+ALU_LATENCY. Legal-op latency accept-to-rsp_valid = ALU_LATENCY+2 cycles.
- Illegal op: rsp_valid high in T+1.
- Throughput: one operation in flight; req_ready=0 from accept until the cycle after the response handshake. Minimum issue interval ALU_LATENCY+3 cycles with rsp_ready tied high.
- req_valid while busy is ignored; caller keeps it asserted.
- Reset mid-operation (any state): in-flight op discarded, no response produced, all outputs to reset values next cycle.
- ALU_LATENCY=1: WAIT lasts exactly one cycle.

## Configuration

- ALU_DRV_CHECK_EN defined: for logic ops, the driver computes the expected result from the registered operands; on capture, a mismatch with alu_result sets chk_mismatch, which stays 1 until reset. Arithmetic ops are not checked.
- Not defined: no checker logic; chk_mismatch tied 0.

## Test plan

- Reset, then op=4'b0100, A=0xF0F0_F0F0, B=0xFF00_FF00, tag=3, rsp_ready=1 -> rsp_valid at accept+5 (ALU_LATENCY=3), rsp_result=0xF000_F000, rsp_zero=0, rsp_tag=3.
- op=4'b0110 (XOR), A=B=0x1234_5678 -> rsp_result=0, rsp_zero=1, rsp_err=0.
- op=4'b1010 (illegal) -> rsp_valid next cycle, rsp_err=1, rsp_result=0, rsp_zero=1; alu_op unchanged.
- Hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, req_ready=0; second req_valid not accepted until one cycle after handshake.
- Assert reset during WAIT -> no response ever appears, rsp_valid=0, alu_op=4'b0100, busy=0 next cycle.
- With ALU_DRV_CHECK_EN, ALU model forcing alu_result=0xDEAD_BEEF on an OR op -> chk_mismatch=1 and remains 1 across later correct ops until reset.
